// File: rtl/mem_interface.sv
// LC-3 memory interface: holds MAR/MDR and runs a request/ready handshake with
// external memory, pulsing R on completion and latching a sticky timeout error.
module mem_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] BUS,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_READY,
  output logic [15:0] MDR_OUT,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        R,
  output logic        MEM_ERR
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Counter value on the last permitted ACCESS cycle.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [15:0] mar_reg, mar_next;
  logic [15:0] mdr_reg, mdr_next;
  logic        we_reg, we_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        err_reg, err_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      mar_reg   <= 16'h0000;
      mdr_reg   <= 16'h0000;
      we_reg    <= 1'b0;
      cnt_reg   <= 16'h0000;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      mar_reg   <= mar_next;
      mdr_reg   <= mdr_next;
      we_reg    <= we_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mar_next   = mar_reg;
    mdr_next   = mdr_reg;
    we_next    = we_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (LD_MAR) mar_next = BUS;
        if (MIO_EN) begin
          state_next = ACCESS;
          we_next    = R_W;
        end else if (LD_MDR) begin
          mdr_next = BUS;
        end
      end
      ACCESS: begin
        // Completion is checked first so a ready on the timeout edge wins.
        if (MEM_READY) begin
          if (!we_reg) mdr_next = MEM_RDATA;
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      DONE: begin
        if (LD_MAR) mar_next = BUS;
        if (LD_MDR && !MIO_EN) mdr_next = BUS;
        cnt_next   = 16'h0000;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign MDR_OUT   = mdr_reg;
  assign MEM_WDATA = mdr_reg;
  assign MEM_ADDR  = mar_reg;
  assign MEM_REQ   = (state_reg == ACCESS);
  assign MEM_WE    = we_reg && (state_reg == ACCESS);
  assign R         = (state_reg == DONE);
  assign MEM_ERR   = err_reg;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: a per-cycle vector table plus hand-written
// timeout, sticky-error and mid-access reset sequences.
module tb_mem_interface;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] BUS;
  logic        LD_MAR, LD_MDR, MIO_EN, R_W, MEM_READY;
  logic [15:0] MEM_RDATA;
  logic [15:0] MDR_OUT, MEM_ADDR, MEM_WDATA;
  logic        MEM_REQ, MEM_WE, R, MEM_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  mem_interface #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .BUS(BUS), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MIO_EN(MIO_EN), .R_W(R_W), .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY),
    .MDR_OUT(MDR_OUT), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .R(R), .MEM_ERR(MEM_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ld_mar, ld_mdr, mio_en, r_w, mem_ready;
    logic [15:0] bus, rdata;
    logic [15:0] e_addr, e_mdr;
    logic        e_req, e_we, e_r, e_err;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic ld_mar, ld_mdr, mio_en, r_w, mem_ready,
                              input logic [15:0] bus, rdata, e_addr, e_mdr,
                              input logic e_req, e_we, e_r, e_err);
    vec_t v;
    v.ld_mar = ld_mar; v.ld_mdr = ld_mdr; v.mio_en = mio_en; v.r_w = r_w;
    v.mem_ready = mem_ready; v.bus = bus; v.rdata = rdata;
    v.e_addr = e_addr; v.e_mdr = e_mdr;
    v.e_req = e_req; v.e_we = e_we; v.e_r = e_r; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [15:0] e_addr, e_mdr,
                         input logic e_req, e_we, e_r, e_err);
    chk({tag, ".addr"}, idx, MEM_ADDR, e_addr);
    chk({tag, ".mdr"}, idx, MDR_OUT, e_mdr);
    chk({tag, ".wdata"}, idx, MEM_WDATA, e_mdr);
    chk({tag, ".req"}, idx, {15'd0, MEM_REQ}, {15'd0, e_req});
    chk({tag, ".we"}, idx, {15'd0, MEM_WE}, {15'd0, e_we});
    chk({tag, ".r"}, idx, {15'd0, R}, {15'd0, e_r});
    chk({tag, ".err"}, idx, {15'd0, MEM_ERR}, {15'd0, e_err});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; R_W = 0; MEM_READY = 0;
    BUS = 16'h0000; MEM_RDATA = 16'h0000;
  endtask

  int n_req;

  initial begin
    // Inputs for one edge; expected outputs just after that edge.
    //            mar mdr mio rw rdy bus       rdata     addr      mdr       req we r err
    vecs[0]  = mk(0,  0,  0,  0, 1,  16'h0000, 16'h9999, 16'h0000, 16'h0000, 0, 0, 0, 0);
    vecs[1]  = mk(1,  0,  0,  0, 0,  16'h3000, 16'h0000, 16'h3000, 16'h0000, 0, 0, 0, 0);
    vecs[2]  = mk(0,  1,  0,  0, 0,  16'hBEEF, 16'h0000, 16'h3000, 16'hBEEF, 0, 0, 0, 0);
    vecs[3]  = mk(0,  1,  1,  0, 0,  16'h5555, 16'h0000, 16'h3000, 16'hBEEF, 1, 0, 0, 0);
    vecs[4]  = mk(0,  0,  0,  0, 1,  16'h0000, 16'h1234, 16'h3000, 16'h1234, 0, 0, 1, 0);
    vecs[5]  = mk(0,  0,  0,  0, 0,  16'h0000, 16'h0000, 16'h3000, 16'h1234, 0, 0, 0, 0);
    vecs[6]  = mk(0,  1,  0,  0, 0,  16'hA5A5, 16'h0000, 16'h3000, 16'hA5A5, 0, 0, 0, 0);
    vecs[7]  = mk(0,  0,  1,  1, 0,  16'h0000, 16'h0000, 16'h3000, 16'hA5A5, 1, 1, 0, 0);
    vecs[8]  = mk(1,  0,  0,  0, 0,  16'hFFFF, 16'h0000, 16'h3000, 16'hA5A5, 1, 1, 0, 0);
    vecs[9]  = mk(0,  1,  0,  0, 0,  16'h0000, 16'h0000, 16'h3000, 16'hA5A5, 1, 1, 0, 0);
    vecs[10] = mk(0,  0,  0,  0, 0,  16'h0000, 16'h0000, 16'h3000, 16'hA5A5, 1, 1, 0, 0);
    vecs[11] = mk(0,  0,  0,  0, 1,  16'h0000, 16'hDEAD, 16'h3000, 16'hA5A5, 0, 0, 1, 0);
    vecs[12] = mk(1,  0,  1,  0, 0,  16'h4000, 16'h0000, 16'h4000, 16'hA5A5, 0, 0, 0, 0);

    idle_inputs();
    RESET = 1;
    step();
    step();
    chk_all("reset", 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    RESET = 0;

    for (int i = 0; i < 13; i++) begin
      LD_MAR = vecs[i].ld_mar; LD_MDR = vecs[i].ld_mdr; MIO_EN = vecs[i].mio_en;
      R_W = vecs[i].r_w; MEM_READY = vecs[i].mem_ready;
      BUS = vecs[i].bus; MEM_RDATA = vecs[i].rdata;
      step();
      $display("vec %0d: addr=%h mdr=%h req=%b we=%b r=%b err=%b", i, MEM_ADDR, MDR_OUT, MEM_REQ, MEM_WE, R, MEM_ERR);
      chk_all("vec", i, vecs[i].e_addr, vecs[i].e_mdr, vecs[i].e_req, vecs[i].e_we, vecs[i].e_r, vecs[i].e_err);
    end

    // Timeout: MEM_READY never comes; MAR loaded on the starting edge.
    idle_inputs();
    MIO_EN = 1; LD_MAR = 1; BUS = 16'h5000;
    step();
    idle_inputs();
    n_req = 0;
    while (MEM_REQ === 1'b1 && n_req < 20) begin
      n_req++;
      step();
    end
    $display("timeout: req_cycles=%0d r=%b err=%b mdr=%h", n_req, R, MEM_ERR, MDR_OUT);
    chk("to.req_cycles", 0, 16'(n_req), 16'd4);
    chk_all("to.done", 0, 16'h5000, 16'hA5A5, 0, 0, 1, 1);
    step();
    chk_all("to.idle", 0, 16'h5000, 16'hA5A5, 0, 0, 0, 1);

    // A later good read leaves the error flag set.
    MIO_EN = 1;
    step();
    chk_all("rd2.acc", 0, 16'h5000, 16'hA5A5, 1, 0, 0, 1);
    idle_inputs();
    MEM_READY = 1; MEM_RDATA = 16'h7777;
    step();
    idle_inputs();
    $display("read after timeout: mdr=%h r=%b err=%b", MDR_OUT, R, MEM_ERR);
    chk_all("rd2.done", 0, 16'h5000, 16'h7777, 0, 0, 1, 1);
    step();
    chk_all("rd2.idle", 0, 16'h5000, 16'h7777, 0, 0, 0, 1);

    RESET = 1;
    step();
    RESET = 0;
    chk_all("errclr", 0, 16'h0000, 16'h0000, 0, 0, 0, 0);

    // Reset during the second ACCESS cycle aborts without an R pulse.
    LD_MAR = 1; BUS = 16'h1111;
    step();
    idle_inputs();
    LD_MDR = 1; BUS = 16'h2222;
    step();
    idle_inputs();
    MIO_EN = 1; R_W = 1;
    step();
    idle_inputs();
    step();
    chk_all("mid.acc2", 0, 16'h1111, 16'h2222, 1, 1, 0, 0);
    RESET = 1;
    step();
    RESET = 0;
    $display("mid-access reset: req=%b r=%b addr=%h mdr=%h", MEM_REQ, R, MEM_ADDR, MDR_OUT);
    chk_all("mid.rst", 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    MEM_READY = 1; MEM_RDATA = 16'hCAFE;
    step();
    chk_all("mid.after", 0, 16'h0000, 16'h0000, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
